// File: rtl/pingpong_frame_player.sv
// Ping-pong frame buffer between the upstream sample stream and the audio-rate player.
// The writer fills one bank while the player drains the other, and each bank is released when its last sample plays.
module pingpong_frame_player #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  underrun,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [0:2*FRAME_LEN-1];
  logic [DATA_WIDTH-1:0] rd_q;

  state_t            state;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic              dout_is_data;

  logic accept;
  logic wr_last;
  logic rd_last;
  logic play_tick;

  // rst_n gates s_ready so that it drops together with the asynchronous reset
  assign s_ready   = enable & rst_n & ~full[wr_bank];
  assign accept    = s_valid & s_ready;
  assign wr_last   = (wr_cnt == LAST_IDX);
  assign rd_last   = (rd_cnt == LAST_IDX);
  assign play_tick = enable & sample_tick & (state == PLAY);

  // The held read register stays free of reset so it maps onto a block RAM output;
  // silence is produced by masking it instead of loading zero into it.
  assign dout = dout_is_data ? rd_q : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wr_bank, wr_cnt}] <= s_data;
    end
    if (play_tick) begin
      rd_q <= mem[{rd_bank, rd_cnt}];
    end
  end

  // The writer only ever fills an empty bank and the player only ever drains a full one,
  // so the set and the clear below always land on different bits.
  always_comb begin
    full_nxt = full;
    if (accept && wr_last) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (play_tick && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      full         <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      dout_is_data <= 1'b0;
      dout_valid   <= 1'b0;
      underrun     <= 1'b0;
      frame_done   <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      full         <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      dout_is_data <= 1'b0;
      dout_valid   <= 1'b0;
      underrun     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      full       <= full_nxt;

      if (accept) begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
        if (wr_last) begin
          wr_bank <= ~wr_bank;
        end
      end

      case (state)
        IDLE: begin
          state <= PRIME;
        end
        PRIME: begin
          if (sample_tick) begin
            dout_valid   <= 1'b1;
            dout_is_data <= 1'b0;
          end
          if (full[rd_bank]) begin
            state <= PLAY;
          end
        end
        PLAY: begin
          if (sample_tick) begin
            dout_valid   <= 1'b1;
            dout_is_data <= 1'b1;
            rd_cnt       <= rd_cnt + ADDR_W'(1);
            if (rd_last) begin
              rd_bank    <= ~rd_bank;
              frame_done <= 1'b1;
              // Judged on the registered flag: a bank completed in this same cycle counts from the next one
              if (!full[~rd_bank]) begin
                state    <= PRIME;
                underrun <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
